// File: rtl/mux_arb_n.sv
// N-channel arbitrating multiplexer with a single registered output slot.
// Grant is fixed-priority (MODE=0) or round-robin (MODE=1), with an optional
// manual select override. One beat per cycle sustained through the output
// register.
module mux_arb_n #(
  parameter int unsigned N    = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = 1,
  localparam int unsigned SW  = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  input  logic             sel_en,
  input  logic [SW-1:0]    sel,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SW-1:0]    out_ch,
  input  logic             out_ready
);

  localparam logic [SW:0] NV = (SW+1)'(N);

  logic [SW-1:0] ptr;
  logic [N-1:0]  grant;
  logic [SW-1:0] g_idx;
  logic [SW-1:0] ptr_next;
  logic [SW:0]   pos;
  logic          found;
  logic          space;
  logic          xfer_in;
  logic [W-1:0]  ch_data [N];

  // Unpack the flat data bus into per-channel words.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign ch_data[gi] = in_data[gi*W +: W];
  end

  // Grant selection: manual override, else a circular search starting at ptr
  // (round-robin) or at 0 (fixed priority). ptr < N, so one wrap subtraction
  // keeps the search position in range.
  always_comb begin
    grant = '0;
    g_idx = '0;
    found = 1'b0;
    pos   = '0;
    if (sel_en) begin
      if (({1'b0, sel} < NV) && in_valid[sel]) begin
        grant[sel] = 1'b1;
        g_idx      = sel;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        pos = (MODE == 0) ? (SW+1)'(k) : ({1'b0, ptr} + (SW+1)'(k));
        if (pos >= NV) pos = pos - NV;
        if (!found && in_valid[pos[SW-1:0]]) begin
          grant[pos[SW-1:0]] = 1'b1;
          g_idx              = pos[SW-1:0];
          found              = 1'b1;
        end
      end
    end
  end

  // Handshake: accept only when the output slot is free or draining.
  assign space    = ~out_valid | out_ready;
  assign in_ready = (space && !reset) ? grant : '0;
  assign xfer_in  = |in_ready;
  assign ptr_next = (g_idx == SW'(N-1)) ? '0 : g_idx + 1'b1;

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer_in) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[g_idx];
        out_ch    <= g_idx;
        if (!sel_en && MODE == 1) ptr <= ptr_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Self-checking bench for mux_arb_n: round-robin, fixed-priority and a
// 2-channel 1-bit instance, driven from vector tables and short sequences.
module tb_mux_arb_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance a: N=4, W=8, round-robin
  logic [3:0]  a_in_valid, a_in_ready;
  logic [31:0] a_in_data;
  logic        a_sel_en, a_out_valid, a_out_ready;
  logic [1:0]  a_sel, a_out_ch;
  logic [7:0]  a_out_data;

  // Instance b: N=4, W=8, fixed priority
  logic [3:0]  b_in_valid, b_in_ready;
  logic [31:0] b_in_data;
  logic        b_sel_en, b_out_valid, b_out_ready;
  logic [1:0]  b_sel, b_out_ch;
  logic [7:0]  b_out_data;

  // Instance c: N=2, W=1
  logic [1:0]  c_in_valid, c_in_ready, c_in_data;
  logic        c_sel_en, c_sel, c_out_valid, c_out_data, c_out_ch, c_out_ready;

  mux_arb_n #(.N(4), .W(8), .MODE(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .sel_en(a_sel_en), .sel(a_sel),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_ready(a_out_ready));

  mux_arb_n #(.N(4), .W(8), .MODE(0)) u_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .sel_en(b_sel_en), .sel(b_sel),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_ready(b_out_ready));

  mux_arb_n #(.N(2), .W(1), .MODE(1)) u_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .sel_en(c_sel_en), .sel(c_sel),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_ch(c_out_ch),
    .out_ready(c_out_ready));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } beat_t;

  typedef struct packed {
    logic [3:0] v;
    logic       se;
    logic [1:0] s;
    logic       ordy;
    logic       ev;
    logic [1:0] ech;
    logic [7:0] ed;
  } vec_t;

  beat_t sb_a[$];
  beat_t sb_c[$];
  logic  m_valid;
  int    mptr;
  int    cptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference grant for a 4-channel round-robin arbiter.
  function automatic int rr_pick(input logic [3:0] v, input logic se,
                                 input logic [1:0] s, input int p);
    if (se) return v[s] ? int'(s) : -1;
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // One clock of instance a against the scoreboard model.
  task automatic a_cycle();
    int g;
    logic [3:0] er;
    beat_t bt;
    #1;
    g  = rr_pick(a_in_valid, a_sel_en, a_sel, mptr);
    er = '0;
    if (g >= 0 && (!m_valid || a_out_ready)) er[g] = 1'b1;
    check("a_in_ready", a_in_ready, er);
    check("a_out_valid", a_out_valid, m_valid);
    if (m_valid && sb_a.size() > 0) begin
      check("a_out_data", a_out_data, sb_a[0].data);
      check("a_out_ch", a_out_ch, sb_a[0].ch);
    end
    @(posedge clk); #1;
    if (m_valid && a_out_ready) begin
      void'(sb_a.pop_front());
      m_valid = 1'b0;
    end
    if (er != 4'b0) begin
      bt.data = a_in_data[g*8 +: 8];
      bt.ch   = 2'(g);
      sb_a.push_back(bt);
      m_valid = 1'b1;
      if (!a_sel_en) mptr = (g + 1) % 4;
    end
  endtask

  vec_t tv[11];

  initial begin
    tv[0]  = '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 8'hA0};
    tv[1]  = '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 8'hA1};
    tv[2]  = '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 8'hA2};
    tv[3]  = '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 8'hA3};
    tv[4]  = '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 8'hA0};
    tv[5]  = '{4'hF, 1'b1, 2'd3, 1'b1, 1'b1, 2'd3, 8'hA3};
    tv[6]  = '{4'hF, 1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 8'hA1};
    tv[7]  = '{4'hB, 1'b1, 2'd2, 1'b1, 1'b0, 2'd1, 8'hA1};
    tv[8]  = '{4'h0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 8'hA1};
    tv[9]  = '{4'h1, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 8'hA0};
    tv[10] = '{4'h8, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 8'hA3};

    m_valid = 1'b0;
    mptr    = 0;
    cptr    = 0;
    reset   = 1'b1;
    a_in_valid = 4'hF; a_in_data = 32'hA3A2A1A0; a_sel_en = 1'b0; a_sel = 2'd0; a_out_ready = 1'b1;
    b_in_valid = 4'hF; b_in_data = 32'hA3A2A1A0; b_sel_en = 1'b0; b_sel = 2'd0; b_out_ready = 1'b1;
    c_in_valid = 2'b00; c_in_data = 2'b00; c_sel_en = 1'b0; c_sel = 1'b0; c_out_ready = 1'b1;

    // Reset state, with requests pending that must not be accepted
    #12;
    check("rst_a_out_valid", a_out_valid, 1'b0);
    check("rst_a_out_data", a_out_data, 8'h00);
    check("rst_a_out_ch", a_out_ch, 2'd0);
    check("rst_a_in_ready", a_in_ready, 4'b0000);
    check("rst_b_in_ready", b_in_ready, 4'b0000);
    check("rst_c_out_valid", c_out_valid, 1'b0);
    a_in_valid = 4'h0;
    b_in_valid = 4'h0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Round-robin / override vector table on instance a
    for (int i = 0; i < 11; i++) begin
      a_in_valid  = tv[i].v;
      a_sel_en    = tv[i].se;
      a_sel       = tv[i].s;
      a_out_ready = tv[i].ordy;
      a_cycle();
      check($sformatf("vec%0d_valid", i), a_out_valid, tv[i].ev);
      check($sformatf("vec%0d_ch", i), a_out_ch, tv[i].ech);
      check($sformatf("vec%0d_data", i), a_out_data, tv[i].ed);
    end
    a_sel_en = 1'b0;

    // Backpressure: one beat from ch2 held across 5 stalled cycles
    a_in_valid = 4'h0; a_out_ready = 1'b1;
    a_cycle();
    check("drain_valid", a_out_valid, 1'b0);
    a_in_data[23:16] = 8'h5C;
    a_in_valid = 4'b0100; a_out_ready = 1'b0;
    a_cycle();
    check("load5c_valid", a_out_valid, 1'b1);
    check("load5c_data", a_out_data, 8'h5C);
    check("load5c_ch", a_out_ch, 2'd2);
    a_in_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      a_cycle();
      check("stall_ready", a_in_ready, 4'b0000);
      check("stall_data", a_out_data, 8'h5C);
      check("stall_ch", a_out_ch, 2'd2);
      check("stall_valid", a_out_valid, 1'b1);
    end
    a_in_valid = 4'h0; a_out_ready = 1'b1;
    a_cycle();
    check("consume_valid", a_out_valid, 1'b0);
    check("consume_hold", a_out_data, 8'h5C);
    a_in_data[23:16] = 8'hA2;

    // Fixed priority on instance b: 4'b1010 always grants ch1
    b_in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fp_in_ready", b_in_ready, 4'b0010);
      @(posedge clk); #1;
      check("fp_valid", b_out_valid, 1'b1);
      check("fp_ch", b_out_ch, 2'd1);
      check("fp_data", b_out_data, 8'hA1);
    end
    b_in_valid = 4'h0;
    @(posedge clk); #1;
    check("fp_idle_valid", b_out_valid, 1'b0);

    // Exhaustive 2-channel, 1-bit sweep on instance c
    for (int v = 0; v < 64; v++) begin
      logic [5:0] vv;
      int cg;
      logic [1:0] er;
      beat_t bt;
      vv = 6'(v);
      c_in_valid = vv[1:0];
      c_in_data  = vv[3:2];
      c_sel_en   = vv[4];
      c_sel      = vv[5];
      #1;
      cg = -1;
      if (c_sel_en) begin
        if (c_in_valid[c_sel]) cg = int'(c_sel);
      end else if (c_in_valid[cptr]) cg = cptr;
      else if (c_in_valid[1 - cptr]) cg = 1 - cptr;
      er = '0;
      if (cg >= 0) begin
        er[cg]  = 1'b1;
        bt.data = {7'b0, c_in_data[cg]};
        bt.ch   = 2'(cg);
        sb_c.push_back(bt);
        if (!c_sel_en) cptr = 1 - cg;
      end
      check($sformatf("sw%0d_ready", v), c_in_ready, er);
      @(posedge clk); #1;
      if (sb_c.size() > 0) begin
        bt = sb_c.pop_front();
        check($sformatf("sw%0d_valid", v), c_out_valid, 1'b1);
        check($sformatf("sw%0d_data", v), c_out_data, bt.data[0]);
        check($sformatf("sw%0d_ch", v), c_out_ch, bt.ch[0]);
      end else begin
        check($sformatf("sw%0d_valid", v), c_out_valid, 1'b0);
      end
    end
    c_in_valid = 2'b00;
    c_sel_en   = 1'b0;

    // Asynchronous reset between edges while a beat is held
    a_in_valid = 4'b0001; a_out_ready = 1'b0;
    a_cycle();
    check("pre_rst_valid", a_out_valid, 1'b1);
    a_in_valid = 4'hF;
    #2 reset = 1'b1;
    #1;
    check("arst_valid", a_out_valid, 1'b0);
    check("arst_data", a_out_data, 8'h00);
    check("arst_ch", a_out_ch, 2'd0);
    check("arst_ready", a_in_ready, 4'b0000);
    a_in_valid = 4'h0;
    reset = 1'b0;
    sb_a.delete();
    m_valid = 1'b0;
    mptr = 0;
    cptr = 0;
    @(posedge clk); #1;
    a_in_valid = 4'hF; a_out_ready = 1'b1;
    a_cycle();
    check("post_rst_ch", a_out_ch, 2'd0);
    check("post_rst_valid", a_out_valid, 1'b1);
    check("post_rst_data", a_out_data, 8'hA0);
    a_in_valid = 4'h0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
